// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_pkg;

    // Transmit FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } tx_state_e;

    // Parity modes
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // 50 MHz system clock, 9600 baud
    localparam int DEFAULT_CLK_DIV = 5208;

    // Widest supported data word; narrower words are zero-extended
    localparam int MAX_DATA_W = 8;

    // Parity bit for a zero-extended word: even mode makes the total count
    // of ones even, odd mode makes it odd.
    function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] word, input int mode);
        logic even_s;
        even_s = ^word;
        if (mode == PAR_ODD) begin
            parity_bit = ~even_s;
        end else begin
            parity_bit = even_s;
        end
    endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// First-word-fall-through synchronous FIFO; the head word is always
// visible on rd_data while the FIFO is non-empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             wr_ok_s;
    logic             rd_ok_s;

    // Qualify requests so overflow and underflow never corrupt state
    always_comb begin
        wr_ok_s = wr_en && (count_q != FULL_CNT);
        rd_ok_s = rd_en && (count_q != '0);
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally (DEPTH is a power of two)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_ok_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({wr_ok_s, rd_ok_s})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: configurable data width, parity and stop bits,
// with a write-side FIFO so frames go out back-to-back.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = DEFAULT_CLK_DIV,
    parameter int DATA_W     = 8,
    parameter int PARITY     = PAR_NONE,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             data,
    input  logic                          flag,
    output logic                          full,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          drop,
    output logic                          tx
);

    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int IDX_W  = 3;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]  DATA_LAST = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0]  STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic              PAR_EN    = (PARITY != PAR_NONE);

    // Reject unsupported configurations at elaboration
    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("uart_tx_fifo: CLK_DIV must be >= 2");
    end
    if ((DATA_W < 5) || (DATA_W > 8)) begin : g_bad_data_w
        $error("uart_tx_fifo: DATA_W must be 5..8");
    end
    if ((PARITY < 0) || (PARITY > 2)) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    tx_state_e         state_q;
    logic [BAUD_W-1:0] baud_q;
    logic [IDX_W-1:0]  bit_idx_q;
    logic [DATA_W-1:0] shift_q;
    logic              parity_q;
    logic              tx_q;
    logic              drop_q;

    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [LVL_W-1:0]  fifo_count_s;
    logic [DATA_W-1:0] fifo_rd_data_s;
    logic              push_s;
    logic              pop_s;
    logic              baud_wrap_s;
    logic              frame_end_s;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_s),
        .wr_data (data),
        .rd_en   (pop_s),
        .rd_data (fifo_rd_data_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    // Bit-boundary detection and FIFO handshakes; a pop happens from IDLE or
    // exactly at the end of the last stop bit, so frames chain with no gap
    always_comb begin
        baud_wrap_s = (baud_q == BAUD_LAST);
        frame_end_s = (state_q == ST_STOP) && baud_wrap_s && (bit_idx_q == STOP_LAST);
        pop_s       = !fifo_empty_s && ((state_q == ST_IDLE) || frame_end_s);
        push_s      = flag && !fifo_full_s;
    end

    // Baud counter: held at zero while idle, otherwise counts 0..CLK_DIV-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_q <= '0;
        end else if ((state_q == ST_IDLE) || baud_wrap_s) begin
            baud_q <= '0;
        end else begin
            baud_q <= baud_q + BAUD_W'(1);
        end
    end

    // Frame sequencer; tx is registered from the current state, so the line
    // trails the state by one cycle (start bit appears the cycle after a pop)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_idx_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            case (state_q)
                ST_START: tx_q <= 1'b0;
                ST_DATA:  tx_q <= shift_q[0];
                ST_PAR:   tx_q <= parity_q;
                ST_STOP:  tx_q <= 1'b1;
                default:  tx_q <= 1'b1;
            endcase

            case (state_q)
                ST_IDLE: begin
                    if (pop_s) begin
                        shift_q   <= fifo_rd_data_s;
                        parity_q  <= parity_bit(MAX_DATA_W'(fifo_rd_data_s), PARITY);
                        bit_idx_q <= '0;
                        state_q   <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_wrap_s) begin
                        bit_idx_q <= '0;
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (baud_wrap_s) begin
                        shift_q <= {1'b0, shift_q[DATA_W-1:1]};
                        if (bit_idx_q == DATA_LAST) begin
                            bit_idx_q <= '0;
                            state_q   <= PAR_EN ? ST_PAR : ST_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + IDX_W'(1);
                        end
                    end
                end
                ST_PAR: begin
                    if (baud_wrap_s) begin
                        bit_idx_q <= '0;
                        state_q   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (baud_wrap_s) begin
                        if (bit_idx_q == STOP_LAST) begin
                            bit_idx_q <= '0;
                            if (pop_s) begin
                                shift_q  <= fifo_rd_data_s;
                                parity_q <= parity_bit(MAX_DATA_W'(fifo_rd_data_s), PARITY);
                                state_q  <= ST_START;
                            end else begin
                                state_q  <= ST_IDLE;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Overflow flag: a write while full is discarded, even if a pop
    // frees a slot on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= 1'b0;
        end else begin
            drop_q <= flag && fifo_full_s;
        end
    end

    assign tx    = tx_q;
    assign drop  = drop_q;
    assign full  = fifo_full_s;
    assign level = fifo_count_s;
    assign busy  = (state_q != ST_IDLE) || (fifo_count_s != '0);

endmodule
